// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 scan-code tracker: resolves E0/F0 prefixes, skips the Pause sequence,
// and keeps held/press/release state for a parameterised list of keys.
module ps2_key_tracker #(
  parameter int NUM_KEYS = 9,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {9'h174, 9'h16B, 9'h172, 9'h175, 9'h05A,
                                                9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_held,
  output logic                code_valid,
  output logic [8:0]          last_code,
  output logic                last_is_break,
  output logic                seq_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic                any_q, any_d;
  logic                valid_q, valid_d;
  logic [8:0]          last_code_q, last_code_d;
  logic                last_brk_q, last_brk_d;
  logic                seq_err_q, seq_err_d;

  logic                do_make_s, do_break_s;
  logic [8:0]          res_code_s;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= IDLE;
      skip_q      <= 3'd0;
      tcnt_q      <= '0;
      held_q      <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_q       <= 1'b0;
      valid_q     <= 1'b0;
      last_code_q <= 9'h000;
      last_brk_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      tcnt_q      <= tcnt_d;
      held_q      <= held_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_q       <= any_d;
      valid_q     <= valid_d;
      last_code_q <= last_code_d;
      last_brk_q  <= last_brk_d;
      seq_err_q   <= seq_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    tcnt_d      = tcnt_q;
    held_d      = held_q;
    press_d     = '0;
    release_d   = '0;
    valid_d     = 1'b0;
    last_code_d = last_code_q;
    last_brk_d  = last_brk_q;
    seq_err_d   = 1'b0;
    do_make_s   = 1'b0;
    do_break_s  = 1'b0;
    res_code_s  = {1'b0, received_data};

    if (received_data_en) begin
      // A byte always wins over a timeout expiring in the same cycle.
      tcnt_d = '0;
      case (state_q)
        IDLE: begin
          case (received_data)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = SKIP;
              skip_d  = 3'd7;
            end
            8'h00, 8'hFA, 8'hFE, 8'hEE, 8'hFF: state_d = IDLE;
            8'hAA: held_d = '0;
            default: do_make_s = 1'b1;
          endcase
        end
        EXT: begin
          if (received_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (received_data == 8'hE0) begin
            state_d = EXT;
          end else begin
            do_make_s  = 1'b1;
            res_code_s = {1'b1, received_data};
            state_d    = IDLE;
          end
        end
        BRK: begin
          if (received_data == 8'hF0) begin
            state_d = BRK;
          end else begin
            do_break_s = 1'b1;
            state_d    = IDLE;
          end
        end
        EXT_BRK: begin
          if ((received_data == 8'hE0) || (received_data == 8'hF0)) begin
            state_d = EXT_BRK;
          end else begin
            do_break_s = 1'b1;
            res_code_s = {1'b1, received_data};
            state_d    = IDLE;
          end
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            state_d = IDLE;
          end else begin
            state_d = SKIP;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
        state_d   = IDLE;
        tcnt_d    = '0;
        seq_err_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end else begin
      tcnt_d = '0;
    end

    if (do_make_s || do_break_s) begin
      valid_d     = 1'b1;
      last_code_d = res_code_s;
      last_brk_d  = do_break_s;
    end else begin
      valid_d = 1'b0;
    end

    // Every matching entry updates, so duplicate codes move together.
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (KEY_CODES[9*i +: 9] == res_code_s) begin
        if (do_make_s && !held_q[i]) begin
          held_d[i]  = 1'b1;
          press_d[i] = 1'b1;
        end else if (do_break_s && held_q[i]) begin
          held_d[i]    = 1'b0;
          release_d[i] = 1'b1;
        end else begin
          held_d[i] = held_d[i];
        end
      end else begin
        held_d[i] = held_d[i];
      end
    end

    any_d = |held_d;
  end

  assign key_held      = held_q;
  assign key_press     = press_q;
  assign key_release   = release_q;
  assign any_held      = any_q;
  assign code_valid    = valid_q;
  assign last_code     = last_code_q;
  assign last_is_break = last_brk_q;
  assign seq_error     = seq_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: directed byte sequences push expected
// resolved events; a negedge monitor pops and compares on each code_valid.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] data = 8'h00;
  logic       en = 1'b0;
  logic [8:0] held, press, rel;
  logic       any, cv, lbrk, serr;
  logic [8:0] lcode;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [8:0] code;
    logic       brk;
    logic [8:0] press;
    logic [8:0] rel;
    logic [8:0] held;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  ps2_key_tracker #(.TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .received_data(data),
    .received_data_en(en),
    .key_held(held),
    .key_press(press),
    .key_release(rel),
    .any_held(any),
    .code_valid(cv),
    .last_code(lcode),
    .last_is_break(lbrk),
    .seq_error(serr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [8:0] code, input logic brk, input logic [8:0] p,
                           input logic [8:0] r, input logic [8:0] h);
    exp_t e;
    e.code = code; e.brk = brk; e.press = p; e.rel = r; e.held = h;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data = b;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Monitor: compare each resolved event, and flag pulses with no event.
  always @(negedge clk) begin
    if (resetn) begin
      if (cv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_code_valid", {23'd0, lcode}, 32'h1FF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("last_code", {23'd0, lcode}, {23'd0, e.code});
          check("last_is_break", {31'd0, lbrk}, {31'd0, e.brk});
          check("key_press", {23'd0, press}, {23'd0, e.press});
          check("key_release", {23'd0, rel}, {23'd0, e.rel});
          check("key_held", {23'd0, held}, {23'd0, e.held});
          check("any_held", {31'd0, any}, {31'd0, (e.held != 9'h000)});
        end
      end else begin
        check("stray_pulse", {14'd0, press, rel}, 32'd0);
      end
    end
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_held", {23'd0, held}, 32'd0);
    check("rst_any", {31'd0, any}, 32'd0);
    check("rst_cv", {31'd0, cv}, 32'd0);
    check("rst_last_code", {23'd0, lcode}, 32'd0);
    check("rst_serr", {31'd0, serr}, 32'd0);
    resetn = 1'b1;

    expect_ev(9'h01D, 1'b0, 9'h001, 9'h000, 9'h001); send(8'h1D);
    expect_ev(9'h01D, 1'b0, 9'h000, 9'h000, 9'h001); send(8'h1D);
    expect_ev(9'h01D, 1'b0, 9'h000, 9'h000, 9'h001); send(8'h1D);
    send(8'hF0);
    expect_ev(9'h01D, 1'b1, 9'h000, 9'h001, 9'h000); send(8'h1D);

    send(8'hE0);
    expect_ev(9'h175, 1'b0, 9'h020, 9'h000, 9'h020); send(8'h75);
    expect_ev(9'h01C, 1'b0, 9'h002, 9'h000, 9'h022); send(8'h1C);
    send(8'hE0); send(8'hF0);
    expect_ev(9'h175, 1'b1, 9'h000, 9'h020, 9'h002); send(8'h75);
    expect_ev(9'h075, 1'b0, 9'h000, 9'h000, 9'h002); send(8'h75);

    // Prefix timeout
    send(8'hF0);
    k = 0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (serr) begin
        k = c;
        break;
      end
    end
    n_checks++;
    if (k < 100 || k > 101) begin
      n_fail++;
      $display("FAIL seq_error_timing: got cycle %0d expected 100..101", k);
    end
    @(negedge clk);
    check("seq_error_width", {31'd0, serr}, 32'd0);
    expect_ev(9'h01D, 1'b0, 9'h001, 9'h000, 9'h003); send(8'h1D);

    // Pause sequence resolves nothing
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_ev(9'h023, 1'b0, 9'h008, 9'h000, 9'h00B); send(8'h23);

    // BAT clears all held keys silently
    send(8'hAA);
    check("bat_held", {23'd0, held}, 32'd0);
    check("bat_any", {31'd0, any}, 32'd0);

    // Break of a key that is not held
    send(8'hF0);
    expect_ev(9'h01B, 1'b1, 9'h000, 9'h000, 9'h000); send(8'h1B);

    // Reset mid-sequence, with a strobe that must be dropped
    send(8'hE0);
    @(negedge clk);
    resetn = 1'b0; data = 8'h1D; en = 1'b1;
    @(negedge clk);
    resetn = 1'b1; en = 1'b0;
    check("midrst_held", {23'd0, held}, 32'd0);
    check("midrst_last_code", {23'd0, lcode}, 32'd0);
    check("midrst_cv", {31'd0, cv}, 32'd0);
    expect_ev(9'h075, 1'b0, 9'h000, 9'h000, 9'h000); send(8'h75);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 Set-2 scan-code decoder that sits between `PS2_Controller` and the game logic, replacing the single-byte last-code compare. It resolves E0 (extended) and F0 (break) prefix sequences and tracks the held state of a configurable key list. For every key in the list it produces a level output and one-cycle press and release pulses. Multiple simultaneous keys work, so both players can steer at once. Prefix sequences are protected by a timeout and a Pause-sequence skip.

## Interface
- `NUM_KEYS`, 9, number of tracked keys.
- `KEY_CODES`, {E0 74, E0 6B, E0 72, E0 75, 5A, 23, 1B, 1C, 1D} (index 0 = 1D), packed `9*NUM_KEYS` bits. Entry i is bits [9i+8:9i]: bit 8 = extended flag, bits 7:0 = scan code. Defaults give 0 w, 1 a, 2 s, 3 d, 4 enter, 5 up, 6 down, 7 left, 8 right.
- `TIMEOUT_CYCLES`, 2_500_000 (50 ms at 50 MHz), idle cycles allowed inside a prefix sequence; counter width is clog2(TIMEOUT_CYCLES+1).
- `CLOCK_50` in 1 — sole clock, all logic on posedge.
- `resetn` in 1 — synchronous, active-low (driven from KEY[0]).
- `received_data` in 8 — byte from `PS2_Controller`.
- `received_data_en` in 1 — one-cycle strobe; byte is valid only in this cycle.
- `key_held` out NUM_KEYS — level, 1 while key i is down.
- `key_press` out NUM_KEYS — one-cycle pulse on the make of a not-held key.
- `key_release` out NUM_KEYS — one-cycle pulse on the break of a held key.
- `any_held` out 1 — OR of `key_held`.
- `code_valid` out 1 — one-cycle pulse whenever any make or break resolves, whether or not it is mapped.
- `last_code` out 9 — {ext, code} of the last resolved make/break.
- `last_is_break` out 1 — break flag for `last_code`.
- `seq_error` out 1 — one-cycle pulse on a prefix timeout.

## Operation
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. A state acts only on cycles with `received_data_en`=1.
- IDLE:
  - E0 -> EXT; F0 -> BRK.
  - E1 -> SKIP, with the skip counter set to 7.
  - 00, FA, FE, EE, FF -> ignored, stay IDLE.
  - AA (keyboard BAT) -> clear all `key_held` with no release pulses, stay IDLE.
  - Any other byte -> make {0,byte}, stay IDLE.
- EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> make {1,byte}, then IDLE.
- BRK: F0 -> stay BRK; any other byte -> break {0,byte}, then IDLE.
- EXT_BRK: any byte except E0/F0 -> break {1,byte}, then IDLE; E0/F0 -> stay EXT_BRK.
- SKIP: decrement on each byte; on the byte that takes the counter to 0 -> IDLE. No make/break is emitted.
- Make {x,c}: for every i with KEY_CODES[i] == {x,c}:
  - If not held: set held and pulse press.
  - If already held (typematic repeat): no pulse.
- Break {x,c}: for every matching i:
  - If held: clear held and pulse release.
  - If not held: no effect.
- Duplicate KEY_CODES entries all update together. Unmapped codes affect only `code_valid`/`last_code`/`last_is_break`.
- Timeout: the counter clears on every byte and in IDLE. In EXT, BRK, EXT_BRK or SKIP, when it reaches TIMEOUT_CYCLES: go to IDLE, pulse `seq_error`, keep held state.

## Timing
- All outputs are registered. Byte strobe at edge N -> `key_held`, pulses, `code_valid`, `last_code` and state update at edge N+1.
- Pulses are exactly one cycle wide. A new byte can be accepted on every cycle.
- Reset (`resetn`=0 at a posedge) from any state, including mid-sequence:
  - State = IDLE, counters = 0.
  - `key_held`, `key_press`, `key_release`, `any_held`, `code_valid`, `seq_error`, `last_is_break` = 0; `last_code` = 9'h000.
  - A `received_data_en` strobe during reset is dropped.
- `any_held` is registered, not combinational from `key_held`. It updates in the same cycle as `key_held`.
- The timeout fires on the cycle the counter equals TIMEOUT_CYCLES. A byte arriving in that same cycle takes precedence: the byte is processed and no error is raised.

## Test plan
- Reset then byte 1D -> `key_held`[0]=1, `key_press`=9'h001 for one cycle, `last_code`=9'h01D, `any_held`=1.
- 1D, 1D, 1D (typematic) then F0,1D -> one press pulse only; `key_release`[0] pulses once; `key_held`=0, `last_is_break`=1.
- E0,75 plus 1C held together, then E0,F0,75 -> `key_held` goes 9'h020, then 9'h022, then 9'h002. A plain 75 (no E0) does not touch bit 5 and gives `last_code`=9'h075.
- F0, then no byte for TIMEOUT_CYCLES (set to 100 in the bench) -> `seq_error` pulses at cycle 100 and the FSM is back in IDLE. A following 1D is treated as a make.
- E1,14,77,E1,F0,14,F0,77 then 23 -> no make/break resolved during the Pause sequence; 23 then sets `key_held`[3].
- Key held, then AA -> all held cleared with no release pulse. Separately, `resetn` low after E0 -> the next 75 is a non-extended make.
